// File: rtl/down_counter_ctrl.sv
// rtl/down_counter_ctrl.sv - sequencing controller for a prescaled down-counter
module down_counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done
);

    // Prescaler needs at least one bit even when PRESCALE is 1.
    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        EXPIRE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;

    // A decrement is due when the prescaler has reached its last step.
    assign tick = (presc_q == PRESC_LAST);

    // State, count, prescaler and reload registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
        end
    end

    // Next-state logic; in RUN and HOLD abort wins over pause, pause wins over a tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d  = load_val;
                    reload_d = load_val;
                    presc_d  = '0;
                    // A zero load has nothing to count, so it expires immediately.
                    state_d  = (load_val != '0) ? RUN : EXPIRE;
                end
            end

            RUN: begin
                if (abort) begin
                    count_d = '0;
                    presc_d = '0;
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = HOLD;
                end else if (tick) begin
                    presc_d = '0;
                    // Saturate at zero so the count can never wrap.
                    if (count_q <= WIDTH'(1)) begin
                        count_d = '0;
                        state_d = EXPIRE;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            HOLD: begin
                if (abort) begin
                    count_d = '0;
                    presc_d = '0;
                    state_d = IDLE;
                end else if (!pause) begin
                    // Prescaler keeps its held value so no partial period is lost.
                    state_d = RUN;
                end
            end

            EXPIRE: begin
                count_d = '0;
                if (abort) begin
                    state_d = IDLE;
                end else if (auto_reload && (reload_q != '0)) begin
                    count_d = reload_q;
                    presc_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign count  = count_q;
    assign busy   = (state_q != IDLE);
    assign paused = (state_q == HOLD);
    assign done   = (state_q == EXPIRE);

endmodule

// File: tb/tb_down_counter_ctrl.sv
// tb/tb_down_counter_ctrl.sv - scoreboard bench for down_counter_ctrl
module tb_down_counter_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] load_val;
    logic       pause;
    logic       abort;
    logic       auto_reload;

    logic [3:0] c1, c2;
    logic       b1, b2, p1, p2, d1, d2;
    logic [6:0] obs1, obs2;

    assign obs1 = {c1, b1, p1, d1};
    assign obs2 = {c2, b2, p2, d2};

    down_counter_ctrl #(.WIDTH(4), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .start(start), .load_val(load_val),
        .pause(pause), .abort(abort), .auto_reload(auto_reload),
        .count(c1), .busy(b1), .paused(p1), .done(d1)
    );

    down_counter_ctrl #(.WIDTH(4), .PRESCALE(2)) u_p2 (
        .clk(clk), .reset(reset), .start(start), .load_val(load_val),
        .pause(pause), .abort(abort), .auto_reload(auto_reload),
        .count(c2), .busy(b2), .paused(p2), .done(d2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       st;
        logic [3:0] lv;
        logic       pa;
        logic       ab;
        logic       ar;
        logic [6:0] ex;
    } step_t;

    step_t      stim_q[$];
    logic [6:0] exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;

    // ex = {count, busy, paused, done} expected after the edge that consumes the inputs
    task automatic push(input logic st, input logic [3:0] lv, input logic pa, input logic ab,
                        input logic ar, input logic [3:0] c, input logic b, input logic p,
                        input logic d);
        step_t s;
        s.st = st; s.lv = lv; s.pa = pa; s.ab = ab; s.ar = ar;
        s.ex = {c, b, p, d};
        stim_q.push_back(s);
    endtask

    task automatic drive(input step_t s);
        start       = s.st;
        load_val    = s.lv;
        pause       = s.pa;
        abort       = s.ab;
        auto_reload = s.ar;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0; load_val = 4'd0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if (obs1 !== 7'b0) $display("FAIL reset_p1 got %b want %b", obs1, 7'b0);
        else n_pass++;
        n_total++;
        if (obs2 !== 7'b0) $display("FAIL reset_p2 got %b want %b", obs2, 7'b0);
        else n_pass++;
        start = 1'b1; load_val = 4'd7;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (obs1 !== 7'b0) $display("FAIL reset_held got %b want %b", obs1, 7'b0);
        else n_pass++;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if (obs1 !== 7'b0) $display("FAIL reset_release got %b want %b", obs1, 7'b0);
        else n_pass++;
    endtask

    task automatic test_countdown();
        step_t      s;
        logic [6:0] e;
        int         i = 0;
        do_reset();
        push(1, 4'd5, 0, 0, 0, 4'd5, 1, 0, 0);
        for (int v = 4; v >= 1; v--) push(0, 4'd0, 0, 0, 0, 4'(v), 1, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
        push(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            drive(s);
            exp_q.push_back(s.ex);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs1 !== e) $display("FAIL countdown[%0d] got %b want %b", i, obs1, e);
            else n_pass++;
            i++;
        end
    endtask

    task automatic test_auto_reload();
        step_t      s;
        logic [6:0] e;
        int         i = 0;
        logic       first;
        do_reset();
        for (int per = 0; per < 3; per++) begin
            for (int v = 3; v >= 1; v--) begin
                for (int k = 0; k < 2; k++) begin
                    first = (v == 3) && (k == 0);
                    push(1'((per == 0) && first), 4'd3, 0, 0, 1'((per < 2) || first),
                         4'(v), 1, 0, 0);
                end
            end
            push(0, 4'd3, 0, 0, 1'(per < 2), 4'd0, 1, 0, 1);
        end
        push(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            drive(s);
            exp_q.push_back(s.ex);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs2 !== e) $display("FAIL auto_reload[%0d] got %b want %b", i, obs2, e);
            else n_pass++;
            i++;
        end
    endtask

    task automatic test_pause();
        step_t      s;
        logic [6:0] e;
        int         i = 0;
        do_reset();
        push(1, 4'd6, 0, 0, 0, 4'd6, 1, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd5, 1, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd4, 1, 0, 0);
        repeat (3) push(0, 4'd0, 1, 0, 0, 4'd4, 1, 1, 0);
        push(0, 4'd0, 0, 0, 0, 4'd4, 1, 0, 0);
        for (int v = 3; v >= 1; v--) push(0, 4'd0, 0, 0, 0, 4'(v), 1, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
        push(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            drive(s);
            exp_q.push_back(s.ex);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs1 !== e) $display("FAIL pause[%0d] got %b want %b", i, obs1, e);
            else n_pass++;
            i++;
        end
    endtask

    task automatic test_abort();
        step_t      s;
        logic [6:0] e;
        int         i = 0;
        do_reset();
        push(1, 4'd4, 0, 0, 0, 4'd4, 1, 0, 0);
        push(1, 4'd9, 0, 0, 0, 4'd3, 1, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0);
        push(0, 4'd0, 0, 1, 0, 4'd0, 0, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        push(1, 4'd4, 0, 0, 0, 4'd4, 1, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd3, 1, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, 0);
        push(0, 4'd0, 1, 0, 0, 4'd2, 1, 1, 0);
        push(0, 4'd0, 1, 1, 0, 4'd0, 0, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            drive(s);
            exp_q.push_back(s.ex);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs1 !== e) $display("FAIL abort[%0d] got %b want %b", i, obs1, e);
            else n_pass++;
            i++;
        end
    endtask

    task automatic test_zero_load();
        step_t      s;
        logic [6:0] e;
        int         i = 0;
        do_reset();
        push(1, 4'd0, 0, 0, 1, 4'd0, 1, 0, 1);
        push(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
        push(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
        push(0, 4'd0, 0, 0, 1, 4'd0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            drive(s);
            exp_q.push_back(s.ex);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs1 !== e) $display("FAIL zero_load[%0d] got %b want %b", i, obs1, e);
            else n_pass++;
            i++;
        end
    endtask

    task automatic test_reset_mid_count();
        step_t      s;
        logic [6:0] e;
        int         i = 0;
        do_reset();
        push(1, 4'd15, 0, 0, 0, 4'd15, 1, 0, 0);
        for (int v = 14; v >= 9; v--) push(0, 4'd0, 0, 0, 0, 4'(v), 1, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            drive(s);
            exp_q.push_back(s.ex);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs1 !== e) $display("FAIL mid_reset_pre[%0d] got %b want %b", i, obs1, e);
            else n_pass++;
            i++;
        end
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (obs1 !== 7'b0) $display("FAIL mid_reset_async got %b want %b", obs1, 7'b0);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        i = 0;
        push(1, 4'd15, 0, 0, 0, 4'd15, 1, 0, 0);
        for (int v = 14; v >= 1; v--) push(0, 4'd0, 0, 0, 0, 4'(v), 1, 0, 0);
        push(0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 1);
        push(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            drive(s);
            exp_q.push_back(s.ex);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs1 !== e) $display("FAIL mid_reset_post[%0d] got %b want %b", i, obs1, e);
            else n_pass++;
            i++;
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; load_val = 4'd0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0;
        #1;
        reset = 1'b1;
        test_reset();
        test_countdown();
        test_auto_reload();
        test_pause();
        test_abort();
        test_zero_load();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/down_counter_ctrl.md
Name: down_counter_ctrl

Overview:
Sequencing controller for the 4-bit down-counter datapath. Sits between control logic and the countdown register.
- Loads a start value and gates decrements through a prescaler.
- Supports pause/resume, abort and optional auto-reload.
- Emits a one-cycle done pulse on expiry.

Parameters:
WIDTH, 4, bit width of count, load_val and reload register
PRESCALE, 1, clock cycles per decrement while running; legal range >= 1

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  begin countdown from load_val; sampled only in IDLE
load_val  input  WIDTH  start/reload value, latched on accepted start
pause  input  1  level; freezes countdown while high
abort  input  1  cancel countdown, return to IDLE without done
auto_reload  input  1  sampled in EXPIRE; restart from latched reload value
count  output  WIDTH  current counter value (registered)
busy  output  1  high in RUN, HOLD, EXPIRE
paused  output  1  high in HOLD
done  output  1  one-cycle pulse, high exactly while in EXPIRE

Behaviour:
Reset (async, any time, including mid-count):
- state = IDLE; count, prescaler and reload register = 0.
- done, busy, paused = 0.
- Outputs release synchronously at the first edge after reset deasserts.

States:
- IDLE
  - start=1 with load_val != 0: next edge loads count and reload, clears prescaler, enters RUN.
  - start=1 with load_val == 0: next edge loads count=0 and reload=0, enters EXPIRE.
  - start=0: count holds.
- RUN, priority abort > pause > tick:
  - abort=1: next edge count=0, prescaler=0, enter IDLE. No done pulse.
  - pause=1: next edge enter HOLD. No decrement or prescaler advance on that edge.
  - Otherwise the prescaler increments. When it equals PRESCALE-1, it clears and count decrements on the same edge.
  - A decrement taking count from 1 to 0 enters EXPIRE on that edge.
- HOLD
  - count and prescaler frozen.
  - abort=1: behaves as in RUN, enter IDLE.
  - pause=0: enter RUN next edge; prescaler resumes from its held value.
- EXPIRE (exactly one cycle; count=0, done=1)
  - abort=1: enter IDLE.
  - auto_reload=1 and reload != 0: next edge count = reload, prescaler = 0, enter RUN.
  - Otherwise: enter IDLE, count stays 0.
- start is ignored in RUN, HOLD and EXPIRE.

Timing:
- With PRESCALE=P and load N>0: from the edge that accepts start, count reaches 0 after N*P edges. done is high in the following cycle.
- Auto-reload period is N*P+1 cycles, done pulse to done pulse.
- count never underflows or wraps below 0. The maximum load of 2^WIDTH-1 is legal.
- All outputs are registered or decoded directly from state; no combinational path from inputs to outputs.

Test Plan:
1. Reset, PRESCALE=1, start with load_val=5 -> count 5,4,3,2,1,0 on successive edges; done=1 in exactly one cycle (count=0); busy falls when IDLE is entered.
2. PRESCALE=2, load_val=3, auto_reload=1 -> each value held 2 cycles; done pulses every 7 cycles; count reloads to 3 after each done. Drop auto_reload -> IDLE after the next done.
3. Count at 4, pause high for 3 cycles -> paused=1, count stays 4 for the pause window; after release, decrements resume with no skipped or duplicated values.
4. Abort while count=2, once in RUN and once in HOLD -> next edge count=0, state IDLE, done never asserts. start while RUN is ignored.
5. start with load_val=0 -> EXPIRE next cycle, done=1 once. With auto_reload=1 the block returns to IDLE, not an endless done loop.
6. Assert reset mid-count at count=9 (load 15) between clock edges -> count, busy, done immediately 0. After release, a new start with load_val=15 counts 15..0 normally.
